// File: rtl/fft_pkg.sv
// Shared definitions for the FFT/IRFFT butterfly datapath.
package fft_pkg;

    localparam int FFT_WIDTH   = 32;
    localparam int FFT_SHIFT   = 16;
    localparam int IPE_LATENCY = 4;

    typedef struct packed {
        logic signed [FFT_WIDTH-1:0] re;
        logic signed [FFT_WIDTH-1:0] im;
    } cplx_t;

    // Round-half-up offset added before dropping `shift` fractional bits.
    function automatic longint round_offset(input int shift);
        return longint'(1) <<< (shift - 1);
    endfunction

endpackage

// File: rtl/cmul_conj.sv
// Two-stage conjugate complex multiply t = b*conj(W) with rounding and bypass.
module cmul_conj
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH,
    parameter int SHIFT = FFT_SHIFT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] b_re,
    input  logic [WIDTH-1:0] b_im,
    input  logic [WIDTH-1:0] wr,
    input  logic [WIDTH-1:0] wi,
    input  logic             bypass_n,
    output logic [WIDTH-1:0] t_re,
    output logic [WIDTH-1:0] t_im
);

    localparam logic signed [2*WIDTH-1:0] RND = (2*WIDTH)'(round_offset(SHIFT));

    logic signed [WIDTH-1:0]   br_s, bi_s, wr_s, wi_s;
    logic signed [2*WIDTH-1:0] rr_p2, ii_p2, ir_p2, ri_p2;
    logic signed [WIDTH-1:0]   br_p2, bi_p2;
    logic                      byp_p2;

    assign br_s = b_re;
    assign bi_s = b_im;
    assign wr_s = wr;
    assign wi_s = wi;

    // Bits above WIDTH+SHIFT are dropped, so wrap inside the 2*WIDTH sum is harmless.
    function automatic logic signed [WIDTH-1:0] round_shift(input logic signed [2*WIDTH-1:0] acc);
        logic signed [2*WIDTH-1:0] s;
        s = (acc + RND) >>> SHIFT;
        return s[WIDTH-1:0];
    endfunction

    // S2: full-precision partial products
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rr_p2  <= '0;
            ii_p2  <= '0;
            ir_p2  <= '0;
            ri_p2  <= '0;
            br_p2  <= '0;
            bi_p2  <= '0;
            byp_p2 <= 1'b0;
        end else begin
            rr_p2  <= (2*WIDTH)'(br_s) * (2*WIDTH)'(wr_s);
            ii_p2  <= (2*WIDTH)'(bi_s) * (2*WIDTH)'(wi_s);
            ir_p2  <= (2*WIDTH)'(bi_s) * (2*WIDTH)'(wr_s);
            ri_p2  <= (2*WIDTH)'(br_s) * (2*WIDTH)'(wi_s);
            br_p2  <= br_s;
            bi_p2  <= bi_s;
            byp_p2 <= bypass_n;
        end
    end

    // S3: conjugate combine, round, or pass b straight through
    always_ff @(posedge Clk) begin
        if (Reset) begin
            t_re <= '0;
            t_im <= '0;
        end else if (byp_p2) begin
            t_re <= round_shift(rr_p2 + ii_p2);
            t_im <= round_shift(ir_p2 - ri_p2);
        end else begin
            t_re <= br_p2;
            t_im <= bi_p2;
        end
    end

endmodule

// File: rtl/ipe.sv
// Inverse radix-2 DIT butterfly: out = (a +/- b*conj(W)) / 2, fixed 4-clock latency.
module ipe
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH,
    parameter int SHIFT = FFT_SHIFT
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in0,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic [WIDTH-1:0]   in3,
    input  logic [2*WIDTH-1:0] tf,
    input  logic               bypass_n,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out0,
    output logic [WIDTH-1:0]   out1,
    output logic [WIDTH-1:0]   out2,
    output logic [WIDTH-1:0]   out3
);

    logic signed [WIDTH-1:0] ar_p1, ai_p1, br_p1, bi_p1, wr_p1, wi_p1;
    logic                    byp_p1;
    logic signed [WIDTH-1:0] ar_p2, ai_p2, ar_p3, ai_p3;
    logic signed [WIDTH-1:0] tr_p3, ti_p3;
    logic                    vld_p1, vld_p2, vld_p3;
    logic signed [WIDTH:0]   sum_re, sum_im, dif_re, dif_im;

    // Floor halving of a WIDTH+1 bit sum always fits back into WIDTH bits.
    function automatic logic [WIDTH-1:0] half(input logic signed [WIDTH:0] s);
        return s[WIDTH:1];
    endfunction

    // S1: capture the sample with its twiddle and bypass flag
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ar_p1  <= '0;
            ai_p1  <= '0;
            br_p1  <= '0;
            bi_p1  <= '0;
            wr_p1  <= '0;
            wi_p1  <= '0;
            byp_p1 <= 1'b0;
        end else begin
            ar_p1  <= in0;
            ai_p1  <= in1;
            br_p1  <= in2;
            bi_p1  <= in3;
            wr_p1  <= tf[2*WIDTH-1:WIDTH];
            wi_p1  <= tf[WIDTH-1:0];
            byp_p1 <= bypass_n;
        end
    end

    // S2-S3: twiddle multiply; a is delayed alongside
    cmul_conj #(
        .WIDTH (WIDTH),
        .SHIFT (SHIFT)
    ) u_cmul (
        .Clk      (Clk),
        .Reset    (Reset),
        .b_re     (br_p1),
        .b_im     (bi_p1),
        .wr       (wr_p1),
        .wi       (wi_p1),
        .bypass_n (byp_p1),
        .t_re     (tr_p3),
        .t_im     (ti_p3)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ar_p2 <= '0;
            ai_p2 <= '0;
            ar_p3 <= '0;
            ai_p3 <= '0;
        end else begin
            ar_p2 <= ar_p1;
            ai_p2 <= ai_p1;
            ar_p3 <= ar_p2;
            ai_p3 <= ai_p2;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            vld_p3    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            vld_p1    <= in_valid;
            vld_p2    <= vld_p1;
            vld_p3    <= vld_p2;
            out_valid <= vld_p3;
        end
    end

    // S4: widened add/subtract, then halve
    always_comb begin
        sum_re = (WIDTH+1)'(ar_p3) + (WIDTH+1)'(tr_p3);
        sum_im = (WIDTH+1)'(ai_p3) + (WIDTH+1)'(ti_p3);
        dif_re = (WIDTH+1)'(ar_p3) - (WIDTH+1)'(tr_p3);
        dif_im = (WIDTH+1)'(ai_p3) - (WIDTH+1)'(ti_p3);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out0 <= '0;
            out1 <= '0;
            out2 <= '0;
            out3 <= '0;
        end else begin
            out0 <= half(sum_re);
            out1 <= half(sum_im);
            out2 <= half(dif_re);
            out3 <= half(dif_im);
        end
    end

endmodule

// File: tb/tb_ipe.sv
// Self-checking bench for ipe: directed vector table, random streaming, reset flush.
module tb_ipe;
    import fft_pkg::*;

    localparam int W   = 32;
    localparam int SH  = 16;
    localparam int LAT = IPE_LATENCY;

    typedef struct packed {
        logic [31:0] o0, o1, o2, o3;
    } res_t;

    typedef struct {
        int   ar, ai, br, bi, wr, wi;
        bit   byp;
        res_t e;
    } vec_t;

    logic           Clk = 1'b0;
    logic           Reset;
    logic           in_valid;
    logic [W-1:0]   in0, in1, in2, in3;
    logic [2*W-1:0] tf;
    logic           bypass_n;
    logic           out_valid;
    logic [W-1:0]   out0, out1, out2, out3;

    int   nchk  = 0;
    int   nfail = 0;
    int   cyc   = 0;
    bit   hv[2048];
    res_t he[2048];
    vec_t tbl[6];

    ipe #(.WIDTH(W), .SHIFT(SH)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .tf        (tf),
        .bypass_n  (bypass_n),
        .out_valid (out_valid),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3)
    );

    always #5 Clk = ~Clk;

    // Reference: t = b*conj(W) rounded (or b), outputs are floor((a +/- t)/2).
    function automatic res_t model(int ar, int ai, int br, int bi, int wr, int wi, bit byp);
        longint tr, ti, half_lsb;
        int     t_re, t_im;
        res_t   r;
        half_lsb = longint'(1) << (SH - 1);
        if (byp) begin
            tr   = (longint'(br) * wr + longint'(bi) * wi + half_lsb) >>> SH;
            ti   = (longint'(bi) * wr - longint'(br) * wi + half_lsb) >>> SH;
            t_re = int'(tr);
            t_im = int'(ti);
        end else begin
            t_re = br;
            t_im = bi;
        end
        r.o0 = int'((longint'(ar) + t_re) >>> 1);
        r.o1 = int'((longint'(ai) + t_im) >>> 1);
        r.o2 = int'((longint'(ar) - t_re) >>> 1);
        r.o3 = int'((longint'(ai) - t_im) >>> 1);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle, advance past the edge, then check what should have emerged.
    task automatic step(input bit v, input bit rst, input int ar, input int ai, input int br,
                        input int bi, input int wr, input int wi, input bit byp, input res_t e);
        bit ev;
        Reset    = rst;
        in_valid = v;
        in0      = ar;
        in1      = ai;
        in2      = br;
        in3      = bi;
        tf       = {wr, wi};
        bypass_n = byp;
        hv[cyc]  = v && !rst;
        he[cyc]  = e;
        if (rst)
            for (int k = 1; k < LAT; k++)
                if (cyc - k >= 0) hv[cyc-k] = 1'b0;
        @(posedge Clk);
        #1;
        cyc++;
        if (rst) begin
            chk("rst_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_out0", out0, 32'd0);
            chk("rst_out1", out1, 32'd0);
            chk("rst_out2", out2, 32'd0);
            chk("rst_out3", out3, 32'd0);
        end else begin
            ev = (cyc >= LAT) ? hv[cyc-LAT] : 1'b0;
            chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
            if (ev) begin
                chk("out0", out0, he[cyc-LAT].o0);
                chk("out1", out1, he[cyc-LAT].o1);
                chk("out2", out2, he[cyc-LAT].o2);
                chk("out3", out3, he[cyc-LAT].o3);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, '0);
    endtask

    task automatic rnd_sample(input bit byp);
        int ar, ai, br, bi, wr, wi;
        int edges[6];
        edges = '{32'h7FFFFFFF, 32'h80000000, 0, -1, 1, 32'h00010000};
        ar = $urandom;  ai = $urandom;
        br = $urandom;  bi = $urandom;
        wr = $urandom_range(0, 1) ? int'($urandom_range(0, 32'h1FFFF)) - 32'h10000 : int'($urandom);
        wi = $urandom_range(0, 1) ? int'($urandom_range(0, 32'h1FFFF)) - 32'h10000 : int'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            ar = edges[$urandom_range(0, 5)];
            br = edges[$urandom_range(0, 5)];
            bi = edges[$urandom_range(0, 5)];
        end
        step(1'b1, 1'b0, ar, ai, br, bi, wr, wi, byp, model(ar, ai, br, bi, wr, wi, byp));
    endtask

    initial begin
        int   nsmp;
        int   p;
        bit   byp;
        res_t e;

        tbl[0] = '{ar: 100, ai: 0, br: 20, bi: 0, wr: 32'h10000, wi: 0, byp: 1'b1,
                   e: '{32'd60, 32'd0, 32'd40, 32'd0}};
        tbl[1] = '{ar: 100, ai: 0, br: 20, bi: 0, wr: 0, wi: 32'h10000, byp: 1'b1,
                   e: '{32'd50, -32'sd10, 32'd50, 32'd10}};
        tbl[2] = '{ar: 0, ai: 0, br: 1, bi: 0, wr: 32'h8000, wi: 0, byp: 1'b1,
                   e: '{32'd0, 32'd0, 32'hFFFFFFFF, 32'd0}};
        tbl[3] = '{ar: 32'h7FFFFFFF, ai: 32'h80000000, br: 32'h7FFFFFFF, bi: 32'h80000000,
                   wr: $urandom, wi: $urandom, byp: 1'b0,
                   e: '{32'h7FFFFFFF, 32'h80000000, 32'd0, 32'd0}};
        tbl[4] = '{ar: 0, ai: 0, br: -1, bi: 0, wr: 32'h8000, wi: 0, byp: 1'b1,
                   e: '{32'd0, 32'd0, 32'd0, 32'd0}};
        tbl[5] = '{ar: 10, ai: 10, br: 3, bi: -5, wr: -32'sh10000, wi: 0, byp: 1'b1,
                   e: '{32'd3, 32'd7, 32'd6, 32'd2}};

        step(1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 1'b0, '0);
        step(1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 1'b0, '0);
        idle(2);

        foreach (tbl[i]) begin
            step(1'b1, 1'b0, tbl[i].ar, tbl[i].ai, tbl[i].br, tbl[i].bi,
                 tbl[i].wr, tbl[i].wi, tbl[i].byp, tbl[i].e);
            idle(5);
        end

        // 16 samples on a 1101 valid pattern, bypass toggling per sample
        nsmp = 0;
        p    = 0;
        while (nsmp < 16) begin
            if ((p % 4) != 2) begin
                rnd_sample(nsmp[0]);
                nsmp++;
            end else begin
                idle(1);
            end
            p++;
        end
        idle(6);

        for (int k = 0; k < 150; k++) begin
            byp = $urandom_range(0, 1);
            if ($urandom_range(0, 3) != 0) rnd_sample(byp);
            else idle(1);
        end
        idle(6);

        // Reset with three samples in flight, then a fresh sample afterwards
        rnd_sample(1'b1);
        rnd_sample(1'b0);
        rnd_sample(1'b1);
        step(1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 1'b0, '0);
        idle(2);
        e = model(100, 0, 20, 0, 32'h10000, 0, 1'b1);
        step(1'b1, 1'b0, 100, 0, 20, 0, 32'h10000, 0, 1'b1, e);
        idle(6);

        $display("[TB] %0d tests run, %0d failed", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/ipe.md
Name: ipe

Overview:
- Inverse radix-2 decimation-in-time butterfly processing element for the inverse real-FFT path.
- It is the counterpart of the forward PE: it applies the conjugate twiddle to b first, then performs the add/subtract.
- It takes one complex pair (a, b) per cycle and produces (a + b·conj(W))/2 and (a − b·conj(W))/2.
- Streaming, fully pipelined, valid-qualified, no back-pressure. Sits between the inverse-stage data buffers of the IRFFT datapath.

Parameters:
- WIDTH, 32, bit width of each real/imag sample (two's complement).
- SHIFT, 16, fractional bits of twiddle (Q(WIDTH-SHIFT).SHIFT); 1.0 = 2^SHIFT.

Ports:
- Clk, input, 1, rising-edge clock.
- Reset, input, 1, synchronous, active-high reset.
- in_valid, input, 1, qualifies in0..in3, tf and bypass_n this cycle.
- in0, input, WIDTH, a real.
- in1, input, WIDTH, a imag.
- in2, input, WIDTH, b real.
- in3, input, WIDTH, b imag.
- tf, input, 2*WIDTH, twiddle W: [2*WIDTH-1:WIDTH] = wr, [WIDTH-1:0] = wi (signed).
- bypass_n, input, 1, 0 = skip the multiply (t = b); 1 = t = b·conj(W).
- out_valid, output, 1, qualifies out0..out3.
- out0, output, WIDTH, (a+t) real / 2.
- out1, output, WIDTH, (a+t) imag / 2.
- out2, output, WIDTH, (a−t) real / 2.
- out3, output, WIDTH, (a−t) imag / 2.

Behaviour:
- Reset: while Reset=1 at a clock edge, every pipeline register, out0..out3 and out_valid are cleared to 0. Reset mid-stream discards all in-flight samples; no spurious out_valid appears afterwards.
- All arithmetic is signed.
- Pipeline, fixed latency of 4 clocks from an in_valid edge to the matching out_valid edge. No stalls; throughput is 1 sample per clock.
  - S1: register a, b, wr, wi, bypass_n and valid.
  - S2: four full 2*WIDTH products: br·wr, bi·wi, bi·wr, br·wi. a, b and bypass are delayed alongside.
  - S3: tr = (br·wr + bi·wi + 2^(SHIFT-1)) >>> SHIFT, ti = (bi·wr − br·wi + 2^(SHIFT-1)) >>> SHIFT. Each is truncated to WIDTH bits; overflow wraps. If the delayed bypass_n = 0, then t = b unchanged.
  - S4: sums are formed at WIDTH+1 bits, then arithmetic shift right by 1 (floor), giving an exact WIDTH-bit result that never overflows:
    - out0 = (ar+tr)>>>1
    - out1 = (ai+ti)>>>1
    - out2 = (ar−tr)>>>1
    - out3 = (ai−ti)>>>1
- Data registers load every cycle regardless of valid. Only the valid chain qualifies data. Outputs hold their last computed value between valids, and that value is don't-care to consumers.
- bypass_n and tf are sampled with the same in_valid and travel with their data. Changing bypass_n between back-to-back samples affects only the sample it arrived with.
- Each pipeline stage's valid bit equals the previous stage's valid bit from one clock earlier. Bubbles are preserved exactly.

Decomposition:
- Shared package (fft_pkg):
  - IPE_LATENCY = 4.
  - Helper constant for the rounding offset 2^(SHIFT-1).
  - Complex-sample typedef {re, im} of WIDTH bits, reused by the forward PE and the stage controllers.
- One natural sub-module, cmul_conj. It implements stages S2–S3: a two-stage conjugate complex multiply with rounding and bypass, and carries b and bypass alongside. ipe instantiates it, plus the S1/S4 registers and the valid chain.

Test Plan (WIDTH=32, SHIFT=16):
- Identity twiddle: a=(100,0), b=(20,0), W=(0x10000,0), bypass_n=1, one valid pulse -> 4 clocks later, out_valid=1 for one cycle; out=(60,0,40,0).
- Quarter twiddle: a=(100,0), b=(20,0), W=(0,0x10000) -> t=(0,−20); out=(50,−10,50,10).
- Rounding/floor: a=(0,0), b=(1,0), W=(0x8000,0) -> t=(1,0); out=(0,0,−1,0).
- Bypass extremes: bypass_n=0, a=(0x7FFFFFFF,0x80000000), b=(0x7FFFFFFF,0x80000000), W=random -> out0=0x7FFFFFFF, out1=0x80000000, out2=0, out3=0. No overflow.
- Streaming with bubbles: 16 random samples with in_valid pattern 1101…, bypass_n toggling per sample -> out_valid is the same pattern delayed by 4 clocks. Every output matches the golden model (conj multiply, round, floor/2) sample-for-sample.
- Reset mid-stream: assert Reset for 1 clock while 3 samples are in flight -> next cycle, all outputs and out_valid are 0. No out_valid for the flushed samples. A fresh sample issued after reset emerges correctly 4 clocks later.
